// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types, defaults and byte-merge helper for reg_file_mp
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_RD_PORTS = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    // Widest word the merge helper handles; callers zero-extend and take the low DATA_W bits.
    localparam int MERGE_W = 256;
    localparam int MERGE_B = MERGE_W / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CLR  = 1'b1
    } clr_state_e;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_B-1:0] byte_en
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_B; b++) begin
            if (byte_en[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - pending-write busy vector with per-port lookups
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_PORTS = DEF_RD_PORTS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reserve,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       wr_clear,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       sweep,
    input  logic [ADDR_W-1:0]          sweep_addr,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS-1:0]        busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending;

    // Reserve is applied after the write-clear so a new producer wins over a retiring one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (sweep) begin
            pending[sweep_addr] <= 1'b0;
        end else begin
            if (wr_clear && !(reserve && rsv_addr == wr_addr)) begin
                pending[wr_addr] <= 1'b0;
            end
            if (reserve) begin
                pending[rsv_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_lookup
        assign busy[k] = pending[rd_addr[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with bypass, scoreboard and clear engine
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_PORTS = DEF_RD_PORTS,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       WRITE,
    input  logic [ADDR_W-1:0]          INADDRESS,
    input  logic [DATA_W-1:0]          IN,
    input  logic [DATA_W/8-1:0]        BYTE_EN,
    input  logic [RD_PORTS*ADDR_W-1:0] RDADDRESS,
    output logic [RD_PORTS*DATA_W-1:0] OUT,
    output logic [RD_PORTS-1:0]        BUSY,
    input  logic                       RESERVE,
    input  logic [ADDR_W-1:0]          RSVADDRESS,
    input  logic                       CLEAR,
    output logic                       CLEARING
);

    localparam int   DEPTH = 2 ** ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic BP    = (BYPASS != 0);

    logic [DATA_W-1:0]   mem [DEPTH];
    clr_state_e          state;
    logic [ADDR_W-1:0]   cnt;
    logic                wr_en;
    logic                rsv_en;
    logic [MERGE_W-1:0]  merged_full;
    logic [DATA_W-1:0]   wr_word;
    logic [RD_PORTS-1:0] sb_busy;

    assign CLEARING = (state == CLR);
    assign wr_en    = WRITE && !CLEARING && !(ZR && INADDRESS == '0);
    assign rsv_en   = RESERVE && !CLEARING && !(ZR && RSVADDRESS == '0);

    // One merge serves both the storage write and the bypass path.
    assign merged_full = byte_merge(MERGE_W'(mem[INADDRESS]), MERGE_W'(IN), MERGE_B'(BYTE_EN));
    assign wr_word     = merged_full[DATA_W-1:0];

    if (DATA_W < MERGE_W) begin : g_merge_pad
        logic unused_merge_hi;
        assign unused_merge_hi = ^merged_full[MERGE_W-1:DATA_W];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state <= IDLE;
            cnt   <= '0;
        end else if (state == CLR) begin
            mem[cnt] <= '0;
            cnt      <= cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1)) begin
                state <= IDLE;
            end
        end else begin
            if (CLEAR) begin
                state <= CLR;
                cnt   <= '0;
            end
            if (wr_en) begin
                mem[INADDRESS] <= wr_word;
            end
        end
    end

    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .RD_PORTS (RD_PORTS)
    ) u_scoreboard (
        .clk        (CLK),
        .rst        (RESET),
        .reserve    (rsv_en),
        .rsv_addr   (RSVADDRESS),
        .wr_clear   (wr_en),
        .wr_addr    (INADDRESS),
        .sweep      (CLEARING),
        .sweep_addr (cnt),
        .rd_addr    (RDADDRESS),
        .busy       (sb_busy)
    );

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              byp;

        assign ra       = RDADDRESS[k*ADDR_W +: ADDR_W];
        assign zero_hit = ZR && (ra == '0);
        assign byp      = BP && wr_en && (INADDRESS == ra);

        assign OUT[k*DATA_W +: DATA_W] = zero_hit ? '0 : (byp ? wr_word : mem[ra]);
        assign BUSY[k]                 = sb_busy[k] & ~byp;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp (default and 64-bit/4-port builds)
module tb_reg_file_mp;

    logic        clk;
    logic        rst;

    logic        write;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic [3:0]  byte_en;
    logic [9:0]  rd_addr;
    logic [63:0] out_data;
    logic [1:0]  busy;
    logic        reserve;
    logic [4:0]  rsv_addr;
    logic        clear;
    logic        clearing;

    logic         w_write;
    logic [2:0]   w_in_addr;
    logic [63:0]  w_in_data;
    logic [7:0]   w_byte_en;
    logic [11:0]  w_rd_addr;
    logic [255:0] w_out_data;
    logic [3:0]   w_busy;
    logic         w_reserve;
    logic [2:0]   w_rsv_addr;
    logic         w_clear;
    logic         w_clearing;

    int n_cmp;
    int n_mis;
    int clr_cycles;

    reg_file_mp dut (
        .CLK        (clk),
        .RESET      (rst),
        .WRITE      (write),
        .INADDRESS  (in_addr),
        .IN         (in_data),
        .BYTE_EN    (byte_en),
        .RDADDRESS  (rd_addr),
        .OUT        (out_data),
        .BUSY       (busy),
        .RESERVE    (reserve),
        .RSVADDRESS (rsv_addr),
        .CLEAR      (clear),
        .CLEARING   (clearing)
    );

    reg_file_mp #(
        .DATA_W   (64),
        .ADDR_W   (3),
        .RD_PORTS (4)
    ) dut_w (
        .CLK        (clk),
        .RESET      (rst),
        .WRITE      (w_write),
        .INADDRESS  (w_in_addr),
        .IN         (w_in_data),
        .BYTE_EN    (w_byte_en),
        .RDADDRESS  (w_rd_addr),
        .OUT        (w_out_data),
        .BUSY       (w_busy),
        .RESERVE    (w_reserve),
        .RSVADDRESS (w_rsv_addr),
        .CLEAR      (w_clear),
        .CLEARING   (w_clearing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        write   = 1'b0;
        reserve = 1'b0;
        clear   = 1'b0;
        w_write = 1'b0;
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        write   = 1'b1;
        in_addr = a;
        in_data = d;
        byte_en = be;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        write = 1'b0; in_addr = '0; in_data = '0; byte_en = '0; rd_addr = '0;
        reserve = 1'b0; rsv_addr = '0; clear = 1'b0;
        w_write = 1'b0; w_in_addr = '0; w_in_data = '0; w_byte_en = '0; w_rd_addr = '0;
        w_reserve = 1'b0; w_rsv_addr = '0; w_clear = 1'b0;

        // Reset values
        rd_addr = {5'd9, 5'd4};
        @(negedge clk);
        #1;
        check("reset_out", out_data, 64'h0);
        check("reset_busy", {62'h0, busy}, 64'h0);
        check("reset_clearing", {63'h0, clearing}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Full-word write, read next cycle on port 1
        @(negedge clk);
        drive_write(5'd5, 32'hDEADBEEF, 4'hF);
        rd_addr = {5'd5, 5'd1};
        @(negedge clk);
        idle_inputs();
        #1;
        check("wr_full_out1", {32'h0, out_data[63:32]}, 64'hDEADBEEF);
        check("wr_full_busy1", {63'h0, busy[1]}, 64'h0);

        // Partial write with same-cycle bypass on port 0
        @(negedge clk);
        drive_write(5'd5, 32'h11223344, 4'b0101);
        rd_addr = {5'd1, 5'd5};
        #1;
        check("bypass_out0", {32'h0, out_data[31:0]}, 64'hDE22BE44);
        @(negedge clk);
        idle_inputs();
        #1;
        check("partial_stored", {32'h0, out_data[31:0]}, 64'hDE22BE44);

        // Scoreboard reserve / write interaction on r7
        @(negedge clk);
        reserve = 1'b1; rsv_addr = 5'd7;
        rd_addr = {5'd1, 5'd7};
        #1;
        check("rsv_not_yet", {63'h0, busy[0]}, 64'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rsv_visible", {63'h0, busy[0]}, 64'h1);
        @(negedge clk);
        drive_write(5'd7, 32'h00000077, 4'hF);
        reserve = 1'b1; rsv_addr = 5'd7;
        #1;
        check("wr_rsv_bypass_busy", {63'h0, busy[0]}, 64'h0);
        check("wr_rsv_bypass_out", {32'h0, out_data[31:0]}, 64'h77);
        @(negedge clk);
        idle_inputs();
        #1;
        check("wr_rsv_stays_busy", {63'h0, busy[0]}, 64'h1);
        @(negedge clk);
        drive_write(5'd7, 32'h00000088, 4'b0000);
        #1;
        check("wr_be0_busy_same", {63'h0, busy[0]}, 64'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("wr_be0_busy_after", {63'h0, busy[0]}, 64'h0);
        check("wr_be0_no_data", {32'h0, out_data[31:0]}, 64'h77);

        // Zero register ignores write and reserve
        @(negedge clk);
        drive_write(5'd0, 32'h00000055, 4'hF);
        reserve = 1'b1; rsv_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        #1;
        check("zero_out_same", out_data, 64'h0);
        check("zero_busy_same", {62'h0, busy}, 64'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("zero_out_after", out_data, 64'h0);
        check("zero_busy_after", {62'h0, busy}, 64'h0);

        // Fill all entries, then clear with a dropped write and re-CLEAR in the last CLR cycle
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            drive_write(5'(a), 32'h100 + 32'(a), 4'hF);
        end
        @(negedge clk);
        idle_inputs();
        clear = 1'b1;
        rd_addr = {5'd20, 5'd3};
        #1;
        check("clr_not_yet", {63'h0, clearing}, 64'h0);
        clr_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            idle_inputs();
            if (!clearing) break;
            clr_cycles++;
            if (clr_cycles == 11) begin
                #1;
                check("mid_clr_cleared", {32'h0, out_data[31:0]}, 64'h0);
                check("mid_clr_pending", {32'h0, out_data[63:32]}, 64'h114);
            end
            if (clr_cycles == 32) begin
                drive_write(5'd3, 32'h9, 4'hF);
                clear = 1'b1;
            end
        end
        check("clr_cycles", 64'(clr_cycles), 64'd32);
        #1;
        check("clr_done", {63'h0, clearing}, 64'h0);
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            check($sformatf("clr_r%0d_r%0d", a, a + 1), out_data, 64'h0);
        end

        // Reset aborts a clear mid-sweep
        for (int a = 1; a < 5; a++) begin
            @(negedge clk);
            drive_write(5'(a), 32'hA0 + 32'(a), 4'hF);
        end
        @(negedge clk);
        idle_inputs();
        clear = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        check("abort_clearing_pre", {63'h0, clearing}, 64'h1);
        rst = 1'b1;
        #1;
        check("abort_clearing_now", {63'h0, clearing}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("abort_stays_idle", {63'h0, clearing}, 64'h0);
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            check($sformatf("abort_r%0d_r%0d", a, a + 1), out_data, 64'h0);
        end

        // 64-bit, 8-entry, 4-port build
        @(negedge clk);
        w_write = 1'b1; w_in_addr = 3'd5; w_in_data = 64'h0123456789ABCDEF; w_byte_en = 8'hFF;
        w_rd_addr = {3'd0, 3'd5, 3'd2, 3'd5};
        @(negedge clk);
        w_write = 1'b1; w_in_addr = 3'd2; w_in_data = 64'hAAAAAAAAAAAAAAAA; w_byte_en = 8'hF0;
        #1;
        check("w_out0", w_out_data[63:0], 64'h0123456789ABCDEF);
        check("w_out2", w_out_data[191:128], 64'h0123456789ABCDEF);
        check("w_out3_zero", w_out_data[255:192], 64'h0);
        check("w_out1_bypass", w_out_data[127:64], 64'hAAAAAAAA00000000);
        check("w_busy", {60'h0, w_busy}, 64'h0);
        @(negedge clk);
        w_write = 1'b0;
        w_rd_addr = {3'd7, 3'd2, 3'd5, 3'd2};
        #1;
        check("w_r2_p0", w_out_data[63:0], 64'hAAAAAAAA00000000);
        check("w_r5_p1", w_out_data[127:64], 64'h0123456789ABCDEF);
        check("w_r2_p2", w_out_data[191:128], 64'hAAAAAAAA00000000);
        check("w_r7_p3", w_out_data[255:192], 64'h0);
        check("w_clearing", {63'h0, w_clearing}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
